random_sched: RTL and testbench
===============================

# random_sched

Sequencer for the per-replica random-number block. It loads a distinct 64-bit seed into every replica slot at start-up, then walks both random generators (or and tw) through all replica slots for a programmed number of passes. It drives `run`, `init`, `i_seed`, `or_base_id` and `tw_base_id`, and paces itself on the generator `ready`. It sits between the top-level annealing controller and the random block.

## Interface
- `BASE_NUM`, default `base_num` (replica_pkg): number of replica slots; power of two, at least 2.
- `BASE_LOG`, default `base_log` (replica_pkg): width of slot index, log2(`BASE_NUM`).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset; single clock domain.
- `init_req`  in  1  one-cycle pulse: start seed load.
- `init_seed`  in  64  root seed, sampled in the cycle `init_req` is accepted.
- `sweep_req`  in  1  one-cycle pulse: start sweep.
- `sweep_cnt`  in  16  number of full passes, sampled on accept.
- `ready`  in  1  random block ready (or & tw).
- `run`  out  1  one-cycle generate strobe to the random block.
- `init`  out  1  seed-write strobe.
- `i_seed`  out  64  seed value written when `init`=1.
- `or_base_id`  out  `BASE_LOG`  or-generator slot.
- `tw_base_id`  out  `BASE_LOG`  tw-generator slot.
- `busy`  out  1  high from accept until the cycle before `done`.
- `done`  out  1  one-cycle completion pulse, for both init and sweep.

## Operation
- FSM states: IDLE, LOAD, ISSUE, GAP, WAIT, FIN.
- IDLE:
  - `init_req` → LOAD. Latch `init_seed`; slot counter k=0.
  - Otherwise `sweep_req` → ISSUE. Latch `sweep_cnt`; k=0.
  - If both requests are high in the same cycle, init wins and `sweep_req` is dropped.
  - Requests that arrive while not in IDLE are ignored, with no queueing.
- LOAD: one slot per cycle, k=0..`BASE_NUM`-1.
  - `init`=1 and `or_base_id`=k.
  - `i_seed` = `init_seed` + k*64'h9E3779B97F4A7C15, computed modulo 2^64.
  - If that result is 0, `i_seed` = 64'h9E3779B97F4A7C15 instead. A seed of zero is never written.
  - After k=`BASE_NUM`-1 → FIN.
  - `ready` is not consulted in LOAD.
- ISSUE: entered with the latched pass count.
  - If the latched pass count is 0 on entry from IDLE → FIN, with no `run` issued.
  - Otherwise drive `run`=1 for one cycle with `or_base_id`=k and `tw_base_id`=(k+`BASE_NUM`/2) mod `BASE_NUM`, then → GAP.
  - This pairing guarantees the two IDs never collide, so there are no same-slot write races in the seed table.
- GAP: one cycle in which `ready` is ignored (the generator's ready may lag `run` by one cycle), then → WAIT.
- WAIT: hold the IDs until `ready`=1, then advance the slot.
  - If k≠`BASE_NUM`-1: k++ and → ISSUE.
  - If k=`BASE_NUM`-1: k=0 and the pass count is decremented. Count reaching 0 → FIN; otherwise → ISSUE.
- FIN: `done`=1 for one cycle, then → IDLE.
- Base IDs hold their last value outside LOAD/ISSUE/GAP/WAIT. They are not forced to 0 in IDLE.

## Timing
- Reset values, all asynchronous on `reset`=0: state IDLE; `run`, `init`, `busy`, `done` = 0; `or_base_id`=0, `tw_base_id`=`BASE_NUM`/2; `i_seed`=0; counters 0.
- Reset asserted mid-LOAD or mid-sweep aborts immediately: no `done` and no further strobes. Slots already written keep their seeds.
- Accept on cycle T: `busy`=1 and the first `init` or `run` on T+1. All outputs are registered.
- Init duration: `init` high for exactly `BASE_NUM` consecutive cycles (T+1..T+`BASE_NUM`). `done` at T+`BASE_NUM`+1; `busy` falls the same cycle.
- Sweep, with `ready` tied high: one `run` every 3 cycles (ISSUE, GAP, WAIT). Total `run` strobes = `sweep_cnt`*`BASE_NUM`. `done` one cycle after the final WAIT.
- `sweep_cnt`=0: `done` at T+2, zero `run` strobes.
- `run` and `init` are never high in the same cycle.
- IDs are stable from the ISSUE cycle until `ready` is sampled high in WAIT.

## Test plan
- Seed load with `BASE_NUM`=4, `init_seed`=1 → `init` high 4 cycles; `i_seed` = 1, 0x9E3779B97F4A7C16, 0x3C6EF372FE94F82B, 0xDAA66D2C7DDF7440; `or_base_id` 0..3; `done` 5 cycles after accept.
- Zero-seed substitution: `init_seed`=0 → slot 0 receives 0x9E3779B97F4A7C15, never 0.
- Sweep `sweep_cnt`=2, `ready`=1 → 8 `run` pulses spaced 3 cycles apart; or/tw pairs (0,2), (1,3), (2,0), (3,1), repeated twice; single `done`.
- Back-pressure: `ready` held low 10 cycles after the 2nd `run` → IDs stay frozen, no extra `run`; sequence resumes the cycle after `ready` returns.
- Simultaneous `init_req` and `sweep_req` in IDLE → seed load only; a `sweep_req` pulsed during `busy` is ignored. `sweep_cnt`=0 → `done` at T+2 with no `run`.
- `reset` driven low during the 3rd `run` of a sweep → outputs reach reset values the same cycle with no `done`; a fresh `sweep_req` afterwards starts at slot 0.

Source files
------------

// File: rtl/random_sched.sv
// rtl/random_sched.sv - seed-load and sweep sequencer for the per-replica random block
module random_sched #(
   parameter int BASE_NUM = 4,
   parameter int BASE_LOG = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init_req,
   input  logic [63:0]         init_seed,
   input  logic                sweep_req,
   input  logic [15:0]         sweep_cnt,
   input  logic                ready,
   output logic                run,
   output logic                init,
   output logic [63:0]         i_seed,
   output logic [BASE_LOG-1:0] or_base_id,
   output logic [BASE_LOG-1:0] tw_base_id,
   output logic                busy,
   output logic                done
);

   localparam logic [63:0]         GOLDEN = 64'h9E3779B97F4A7C15;
   localparam logic [BASE_LOG-1:0] HALF   = BASE_LOG'(BASE_NUM / 2);
   localparam logic [BASE_LOG-1:0] LAST   = BASE_LOG'(BASE_NUM - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, WAIT, FIN} state_t;

   state_t              state, state_nx;
   logic [BASE_LOG-1:0] k, k_nx, k_inc;
   logic [15:0]         pass_cnt, pass_nx;
   logic [63:0]         acc, acc_nx, acc_inc;
   logic                run_nx, init_nx, busy_nx, done_nx;
   logic [63:0]         seed_nx;
   logic [BASE_LOG-1:0] or_nx, tw_nx;

   // Successive seeds are an additive walk, so no multiplier is needed.
   assign k_inc   = k + BASE_LOG'(1);
   assign acc_inc = acc + GOLDEN;

   function automatic logic [63:0] nz_seed(input logic [63:0] s);
      return (s == 64'd0) ? GOLDEN : s;
   endfunction

   always_comb begin
      state_nx = state;
      k_nx     = k;
      pass_nx  = pass_cnt;
      acc_nx   = acc;
      run_nx   = 1'b0;
      init_nx  = 1'b0;
      done_nx  = 1'b0;
      busy_nx  = busy;
      seed_nx  = i_seed;
      or_nx    = or_base_id;
      tw_nx    = tw_base_id;
      case (state)
         IDLE: begin
            if (init_req) begin
               state_nx = LOAD;
               k_nx     = '0;
               acc_nx   = init_seed;
               busy_nx  = 1'b1;
               init_nx  = 1'b1;
               seed_nx  = nz_seed(init_seed);
               or_nx    = '0;
            end else if (sweep_req) begin
               state_nx = ISSUE;
               k_nx     = '0;
               pass_nx  = sweep_cnt;
               busy_nx  = 1'b1;
               if (sweep_cnt != 16'd0) begin
                  run_nx = 1'b1;
                  or_nx  = '0;
                  tw_nx  = HALF;
               end
            end
         end
         LOAD: begin
            if (k == LAST) begin
               state_nx = FIN;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end else begin
               k_nx    = k_inc;
               acc_nx  = acc_inc;
               init_nx = 1'b1;
               seed_nx = nz_seed(acc_inc);
               or_nx   = k_inc;
            end
         end
         ISSUE: begin
            if (pass_cnt == 16'd0) begin
               state_nx = FIN;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end else begin
               state_nx = GAP;
            end
         end
         GAP: state_nx = WAIT;
         WAIT: begin
            if (ready) begin
               if (k != LAST) begin
                  k_nx     = k_inc;
                  state_nx = ISSUE;
                  run_nx   = 1'b1;
                  or_nx    = k_inc;
                  tw_nx    = k_inc + HALF;
               end else begin
                  k_nx    = '0;
                  pass_nx = pass_cnt - 16'd1;
                  if (pass_cnt == 16'd1) begin
                     state_nx = FIN;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = ISSUE;
                     run_nx   = 1'b1;
                     or_nx    = '0;
                     tw_nx    = HALF;
                  end
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         k          <= '0;
         pass_cnt   <= '0;
         acc        <= '0;
         run        <= 1'b0;
         init       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         i_seed     <= '0;
         or_base_id <= '0;
         tw_base_id <= HALF;
      end else begin
         state      <= state_nx;
         k          <= k_nx;
         pass_cnt   <= pass_nx;
         acc        <= acc_nx;
         run        <= run_nx;
         init       <= init_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         i_seed     <= seed_nx;
         or_base_id <= or_nx;
         tw_base_id <= tw_nx;
      end
   end

endmodule

// File: tb/tb_random_sched.sv
// tb/tb_random_sched.sv - randomized bench for random_sched against a cycle-level behavioural model
module tb_random_sched;

   localparam int          N      = 4;
   localparam int          L      = 2;
   localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

   logic         clk       = 1'b0;
   logic         reset     = 1'b0;
   logic         init_req  = 1'b0;
   logic [63:0]  init_seed = '0;
   logic         sweep_req = 1'b0;
   logic [15:0]  sweep_cnt = '0;
   logic         ready     = 1'b1;
   logic         run, init, busy, done;
   logic [63:0]  i_seed;
   logic [L-1:0] or_base_id, tw_base_id;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   random_sched #(.BASE_NUM(N), .BASE_LOG(L)) dut (
      .clk(clk), .reset(reset), .init_req(init_req), .init_seed(init_seed),
      .sweep_req(sweep_req), .sweep_cnt(sweep_cnt), .ready(ready),
      .run(run), .init(init), .i_seed(i_seed), .or_base_id(or_base_id),
      .tw_base_id(tw_base_id), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bit   rdy_rand  = 1'b0;
   logic rdy_force = 1'b1;
   always @(posedge clk) begin
      #1;
      ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   // Model: expected outputs for the cycle that begins at each rising edge.
   logic         e_run = 0, e_init = 0, e_busy = 0, e_done = 0;
   logic [63:0]  e_seed = '0;
   logic [L-1:0] e_or = '0, e_tw = L'(N / 2);
   bit           m_eng = 0, m_isinit = 0, was_done = 0;
   int           m_k = 0, m_age = 0, m_pass = 0;
   logic [63:0]  m_root = '0;

   function automatic logic [63:0] seed_of(input logic [63:0] root, input int k);
      logic [63:0] s;
      s = root + 64'(k) * GOLDEN;
      return (s == 64'd0) ? GOLDEN : s;
   endfunction

   task automatic issue(input int k);
      e_run = 1'b1;
      e_or  = L'(k % N);
      e_tw  = L'((k + N / 2) % N);
      m_age = 0;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_run = 0; e_init = 0; e_busy = 0; e_done = 0;
         e_seed = '0; e_or = '0; e_tw = L'(N / 2);
         m_eng = 0;
      end else begin
         was_done = e_done;
         e_run = 0; e_init = 0; e_done = 0;
         if (!m_eng) begin
            if (init_req) begin
               m_eng = 1; m_isinit = 1; m_root = init_seed; m_k = 0;
               e_busy = 1; e_init = 1; e_seed = seed_of(init_seed, 0); e_or = '0;
            end else if (sweep_req) begin
               m_eng = 1; m_isinit = 0; m_pass = int'(sweep_cnt); m_k = 0;
               e_busy = 1;
               if (m_pass != 0) issue(0);
            end
         end else if (was_done) begin
            m_eng = 0;
         end else if (m_isinit) begin
            if (m_k == N - 1) begin
               e_done = 1; e_busy = 0;
            end else begin
               m_k++;
               e_init = 1; e_seed = seed_of(m_root, m_k); e_or = L'(m_k);
            end
         end else if (m_pass == 0) begin
            e_done = 1; e_busy = 0;
         end else if (m_age >= 2 && ready) begin
            m_k++;
            if (m_k == N) begin
               m_k = 0;
               m_pass--;
            end
            if (m_pass == 0) begin
               e_done = 1; e_busy = 0;
            end else begin
               issue(m_k);
            end
         end else begin
            m_age++;
         end
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({run, init, busy, done, or_base_id, tw_base_id, i_seed} !==
             {e_run, e_init, e_busy, e_done, e_or, e_tw, e_seed}) begin
            errors++;
            $display("FAIL model cycle %0d: got run=%b init=%b busy=%b done=%b or=%0d tw=%0d seed=%h, want run=%b init=%b busy=%b done=%b or=%0d tw=%0d seed=%h",
                     cyc, run, init, busy, done, or_base_id, tw_base_id, i_seed,
                     e_run, e_init, e_busy, e_done, e_or, e_tw, e_seed);
         end
      end
   end

   int           init_n = 0, done_n = 0, last_done_cyc = -1;
   int           run_cyc[$];
   logic [3:0]   run_pair[$];
   logic [63:0]  seed_log[N];
   always @(negedge clk) begin
      if (run) begin
         run_cyc.push_back(cyc);
         run_pair.push_back({or_base_id, tw_base_id});
      end
      if (init) begin
         init_n++;
         seed_log[or_base_id] = i_seed;
      end
      if (done) begin
         done_n++;
         last_done_cyc = cyc;
      end
   end

   task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_init(input logic [63:0] s, output int t);
      init_req = 1'b1; init_seed = s; t = cyc;
      tick();
      init_req = 1'b0;
   endtask

   task automatic pulse_sweep(input int c, output int t);
      sweep_req = 1'b1; sweep_cnt = 16'(c); t = cyc;
      tick();
      sweep_req = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name, input bit noise);
      int d0 = done_n;
      int n  = 0;
      while (n < budget) begin
         tick();
         n++;
         init_req = 1'b0; sweep_req = 1'b0;
         if (done_n != d0) break;
         if (noise && $urandom_range(0, 7) == 0) begin
            init_seed = {$urandom, $urandom};
            sweep_cnt = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) init_req = 1'b1;
            else sweep_req = 1'b1;
         end
      end
      checks++;
      if (done_n == d0) begin
         errors++;
         $display("FAIL %s: no done within %0d cycles, got %0d done pulses, want 1", name, budget, done_n - d0);
      end
   endtask

   task automatic wait_runs(input int target, input string name);
      int n = 0;
      while (run_pair.size() < target && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (run_pair.size() < target) begin
         errors++;
         $display("FAIL %s: got %0d run strobes, want %0d", name, run_pair.size(), target);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t, r0, i0, d0, rb;
      logic [3:0] exp_pairs[4];
      exp_pairs = '{4'b0010, 4'b0111, 4'b1000, 4'b1101};

      tick();
      chk_en = 1'b1;
      tick(); tick();
      lit("reset_ctrl", 64'({run, init, busy, done}), 64'd0);
      lit("reset_ids", 64'({or_base_id, tw_base_id}), 64'b0010);
      lit("reset_seed", i_seed, 64'd0);
      reset = 1'b1;
      tick();

      // Seed load from root 1
      i0 = init_n;
      pulse_init(64'd1, t);
      wait_done(50, "init_root1", 1'b0);
      lit("init_count", 64'(init_n - i0), 64'd4);
      lit("seed_k0", seed_log[0], 64'h0000000000000001);
      lit("seed_k1", seed_log[1], 64'h9E3779B97F4A7C16);
      lit("seed_k2", seed_log[2], 64'h3C6EF372FE94F82B);
      lit("seed_k3", seed_log[3], 64'hDAA66D2C7DDF7440);
      lit("init_done_latency", 64'(last_done_cyc - t), 64'd5);

      // Zero root seed is substituted
      pulse_init(64'd0, t);
      wait_done(50, "init_root0", 1'b0);
      lit("zero_seed_k0", seed_log[0], 64'h9E3779B97F4A7C15);

      // Two passes with ready high
      rdy_force = 1'b1;
      r0 = run_pair.size(); d0 = done_n;
      pulse_sweep(2, t);
      wait_done(200, "sweep2", 1'b0);
      lit("sweep2_runs", 64'(run_pair.size() - r0), 64'd8);
      lit("sweep2_dones", 64'(done_n - d0), 64'd1);
      if (run_pair.size() - r0 == 8) begin
         for (int j = 0; j < 8; j++)
            lit($sformatf("sweep2_pair%0d", j), 64'(run_pair[r0 + j]), 64'(exp_pairs[j % 4]));
         for (int j = 0; j < 7; j++)
            lit($sformatf("sweep2_gap%0d", j), 64'(run_cyc[r0 + j + 1] - run_cyc[r0 + j]), 64'd3);
      end

      // Back-pressure after the second run
      r0 = run_pair.size();
      pulse_sweep(1, t);
      wait_runs(r0 + 2, "bp_second_run");
      rdy_force = 1'b0;
      rb = run_cyc[run_cyc.size() - 1];
      repeat (10) @(posedge clk);
      #2;
      lit("bp_no_run", 64'(run_pair.size() - r0), 64'd2);
      lit("bp_ids", 64'({or_base_id, tw_base_id}), 64'b0111);
      rdy_force = 1'b1;
      wait_done(200, "bp_sweep", 1'b0);
      if (run_pair.size() - r0 >= 3)
         lit("bp_resume", 64'(run_cyc[r0 + 2] - rb), 64'd12);
      else
         lit("bp_resume_runs", 64'(run_pair.size() - r0), 64'd4);

      // Simultaneous requests, then sweep request while busy
      r0 = run_pair.size(); i0 = init_n;
      init_req = 1'b1; sweep_req = 1'b1; sweep_cnt = 16'd1; init_seed = 64'h0123456789ABCDEF;
      tick();
      init_req = 1'b0; sweep_req = 1'b0;
      tick();
      sweep_req = 1'b1;
      tick();
      sweep_req = 1'b0;
      wait_done(50, "both_req", 1'b0);
      lit("both_req_runs", 64'(run_pair.size() - r0), 64'd0);
      lit("both_req_inits", 64'(init_n - i0), 64'd4);

      // Zero pass count
      r0 = run_pair.size();
      pulse_sweep(0, t);
      wait_done(20, "sweep0", 1'b0);
      lit("sweep0_latency", 64'(last_done_cyc - t), 64'd2);
      lit("sweep0_runs", 64'(run_pair.size() - r0), 64'd0);

      // Reset during the third run
      r0 = run_pair.size(); d0 = done_n;
      pulse_sweep(2, t);
      wait_runs(r0 + 3, "rst_third_run");
      #1;
      reset = 1'b0;
      #1;
      lit("rst_ctrl", 64'({run, init, busy, done}), 64'd0);
      lit("rst_ids", 64'({or_base_id, tw_base_id}), 64'b0010);
      tick(); tick();
      reset = 1'b1;
      repeat (10) tick();
      lit("rst_no_done", 64'(done_n - d0), 64'd0);
      r0 = run_pair.size();
      pulse_sweep(1, t);
      wait_done(100, "post_rst_sweep", 1'b0);
      if (run_pair.size() > r0)
         lit("post_rst_first_pair", 64'(run_pair[r0]), 64'b0010);
      else
         lit("post_rst_runs", 64'(run_pair.size() - r0), 64'd4);

      // Randomized traffic with random ready and stray requests
      rdy_rand = 1'b1;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 3) == 0)
               pulse_init(64'd0 - 64'($urandom_range(0, N - 1)) * GOLDEN, t);
            else
               pulse_init({$urandom, $urandom}, t);
         end else begin
            pulse_sweep($urandom_range(0, 3), t);
         end
         wait_done(600, $sformatf("rand_txn%0d", it), 1'b1);
         repeat ($urandom_range(0, 2)) tick();
      end
      rdy_rand = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
